// File: rtl/adder8b_reg.sv
// adder8b_reg: registered ripple-carry adder with a valid strobe.
// Optional signed-overflow output ovf is enabled by defining ADDER8B_OVF_EN.

module adder8b_fa (
    input  logic i_x,
    input  logic i_y,
    input  logic i_c,
    output logic o_s,
    output logic o_co
);

    logic w_p;

    assign w_p  = i_x ^ i_y;
    assign o_s  = w_p ^ i_c;
    assign o_co = (i_x & i_y) | (i_c & w_p);

endmodule

module adder8b_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [0:WIDTH-1] a,
    input  logic [0:WIDTH-1] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [0:WIDTH-1] sum,
    output logic             cout,
`ifdef ADDER8B_OVF_EN
    output logic             ovf,
`endif
    output logic             out_valid
);

    // w_carry[i+1] feeds cell i, cell i drives w_carry[i];
    // the chain enters at the LSB (index WIDTH-1) and exits at the MSB.
    logic [0:WIDTH]   w_carry;
    logic [0:WIDTH-1] w_sum;

    logic [0:WIDTH-1] r_sum;
    logic             r_cout;
    logic             r_valid;

    assign w_carry[WIDTH] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        adder8b_fa u_fa (
            .i_x  (a[i]),
            .i_y  (b[i]),
            .i_c  (w_carry[i+1]),
            .o_s  (w_sum[i]),
            .o_co (w_carry[i])
        );
    end

    // Result registers: load on a valid beat, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (in_valid) begin
            r_sum  <= w_sum;
            r_cout <= w_carry[0];
        end
    end

    // Valid strobe follows in_valid with one cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
        end
    end

`ifdef ADDER8B_OVF_EN
    logic w_ovf;
    logic r_ovf;

    // Signed overflow: carry into the MSB cell differs from its carry out.
    assign w_ovf = w_carry[1] ^ w_carry[0];

    // Overflow flag shares the load/hold behaviour of the sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (in_valid) begin
            r_ovf <= w_ovf;
        end
    end

    assign ovf = r_ovf;
`endif

    assign sum       = r_sum;
    assign cout      = r_cout;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_adder8b_reg.sv
// tb_adder8b_reg: scoreboard bench for adder8b_reg.
// Define ADDER8B_OVF_EN for both files to exercise the ovf output.

module tb_adder8b_reg;

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       o;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [0:7] a;
    logic [0:7] b;
    logic       cin;
    logic       in_valid;
    logic [0:7] sum;
    logic       cout;
    logic       out_valid;
`ifdef ADDER8B_OVF_EN
    logic       ovf;
`endif

    exp_t sb[$];
    exp_t e;
    exp_t last;
    int   n_cmp;
    int   n_bad;

    adder8b_reg #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .sum       (sum),
        .cout      (cout),
`ifdef ADDER8B_OVF_EN
        .ovf       (ovf),
`endif
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [7:0] xa,
                                   input logic [7:0] xb,
                                   input logic xc);
        exp_t r;
        logic [8:0] u;
        int s;
        u = {1'b0, xa} + {1'b0, xb} + {8'd0, xc};
        s = int'($signed(xa)) + int'($signed(xb)) + int'(xc);
        r.s = u[7:0];
        r.c = u[8];
        r.o = (s > 127) || (s < -128);
        return r;
    endfunction

    // Drive one beat on the falling edge; queue the expected result.
    task automatic drive(input logic v, input logic [7:0] xa,
                         input logic [7:0] xb, input logic xc);
        @(negedge clk);
        in_valid = v;
        a = xa;
        b = xb;
        cin = xc;
        if (v === 1'b1) sb.push_back(model(xa, xb, xc));
    endtask

    task automatic settle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (sum !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_sum got=%h want=00", sum);
        end
        n_cmp++;
        if (cout !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_cout got=%b want=0", cout);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid got=%b want=0", out_valid);
        end
`ifdef ADDER8B_OVF_EN
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ovf got=%b want=0", ovf);
        end
`endif
        last = '{8'h00, 1'b0, 1'b0};
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_carry_in;
        logic [7:0] va [2] = '{8'h03, 8'h04};
        logic [7:0] vb [2] = '{8'h04, 8'h08};
        logic [7:0] want [2] = '{8'h08, 8'h0D};
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, va[i], vb[i], 1'b1);
            settle();
            e = sb.pop_front();
            last = e;
            n_cmp++;
            if (out_valid !== 1'b1 || sum !== want[i] || cout !== 1'b0) begin
                n_bad++;
                $display("FAIL carry_in[%0d] got v=%b s=%h c=%b want v=1 s=%h c=0",
                         i, out_valid, sum, cout, want[i]);
            end
        end
    endtask

    task automatic test_no_carry_in;
        drive(1'b1, 8'h0D, 8'h01, 1'b0);
        settle();
        e = sb.pop_front();
        last = e;
        n_cmp++;
        if (out_valid !== 1'b1 || sum !== 8'h0E || cout !== 1'b0) begin
            n_bad++;
            $display("FAIL no_cin got v=%b s=%h c=%b want v=1 s=0e c=0",
                     out_valid, sum, cout);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 8'hAA, 8'h55, 1'b1);
            settle();
            n_cmp++;
            if (out_valid !== 1'b0 || sum !== 8'h0E || cout !== 1'b0) begin
                n_bad++;
                $display("FAIL hold[%0d] got v=%b s=%h c=%b want v=0 s=0e c=0",
                         i, out_valid, sum, cout);
            end
        end
    endtask

    task automatic test_wraparound;
        logic [7:0] va [2] = '{8'hFF, 8'hFF};
        logic [7:0] vb [2] = '{8'h01, 8'hFF};
        logic       vc [2] = '{1'b0, 1'b1};
        logic [7:0] want [2] = '{8'h00, 8'hFF};
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, va[i], vb[i], vc[i]);
            settle();
            e = sb.pop_front();
            last = e;
            n_cmp++;
            if (sum !== want[i] || cout !== 1'b1 || out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL wrap[%0d] got s=%h c=%b v=%b want s=%h c=1 v=1",
                         i, sum, cout, out_valid, want[i]);
            end
        end
    endtask

    task automatic test_bit_order;
        drive(1'b1, 8'h80, 8'h00, 1'b1);
        settle();
        e = sb.pop_front();
        last = e;
        n_cmp++;
        if (sum[0] !== 1'b1 || sum[7] !== 1'b1) begin
            n_bad++;
            $display("FAIL bit_order got s0=%b s7=%b want s0=1 s7=1",
                     sum[0], sum[7]);
        end
        n_cmp++;
        if (sum !== 8'h81 || cout !== 1'b0) begin
            n_bad++;
            $display("FAIL bit_order_val got s=%h c=%b want s=81 c=0", sum, cout);
        end
    endtask

    task automatic test_x_idle;
        drive(1'b0, 8'hxx, 8'hxx, 1'bx);
        settle();
        n_cmp++;
        if (out_valid !== 1'b0 || sum !== last.s || cout !== last.c) begin
            n_bad++;
            $display("FAIL x_idle got v=%b s=%h c=%b want v=0 s=%h c=%b",
                     out_valid, sum, cout, last.s, last.c);
        end
    endtask

    task automatic test_mid_change;
        drive(1'b1, 8'h12, 8'h34, 1'b0);
        settle();
        e = sb.pop_front();
        last = e;
        #1;
        a = 8'hF0;
        b = 8'h0F;
        cin = 1'b1;
        #1;
        n_cmp++;
        if (sum !== 8'h46 || cout !== 1'b0 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_change got s=%h c=%b v=%b want s=46 c=0 v=1",
                     sum, cout, out_valid);
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        settle();
    endtask

    task automatic test_async_reset;
        drive(1'b1, 8'h55, 8'h22, 1'b0);
        settle();
        e = sb.pop_front();
        n_cmp++;
        if (sum !== 8'h77 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset got s=%h v=%b want s=77 v=1", sum, out_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (sum !== 8'h00 || cout !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset got s=%h c=%b v=%b want s=00 c=0 v=0",
                     sum, cout, out_valid);
        end
        sb.delete();
        last = '{8'h00, 1'b0, 1'b0};
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 8'h01, 8'h02, 1'b0);
        settle();
        e = sb.pop_front();
        last = e;
        n_cmp++;
        if (sum !== 8'h03 || cout !== 1'b0 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset got s=%h c=%b v=%b want s=03 c=0 v=1",
                     sum, cout, out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic v;
        for (int i = 0; i < 40; i++) begin
            v = ($urandom_range(0, 3) != 0);
            drive(v, 8'($urandom), 8'($urandom), 1'($urandom));
            settle();
            if (v) begin
                e = sb.pop_front();
                last = e;
            end
            n_cmp++;
            if (out_valid !== v || sum !== last.s || cout !== last.c) begin
                n_bad++;
                $display("FAIL b2b[%0d] got v=%b s=%h c=%b want v=%b s=%h c=%b",
                         i, out_valid, sum, cout, v, last.s, last.c);
            end
`ifdef ADDER8B_OVF_EN
            n_cmp++;
            if (ovf !== last.o) begin
                n_bad++;
                $display("FAIL b2b_ovf[%0d] got=%b want=%b", i, ovf, last.o);
            end
`endif
        end
    endtask

`ifdef ADDER8B_OVF_EN
    task automatic test_ovf;
        logic [7:0] va [3] = '{8'h7F, 8'h01, 8'h80};
        logic [7:0] vb [3] = '{8'h01, 8'h01, 8'h80};
        logic [7:0] ws [3] = '{8'h80, 8'h02, 8'h00};
        logic       wc [3] = '{1'b0, 1'b0, 1'b1};
        logic       wo [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, va[i], vb[i], 1'b0);
            settle();
            e = sb.pop_front();
            last = e;
            n_cmp++;
            if (sum !== ws[i] || cout !== wc[i] || ovf !== wo[i]) begin
                n_bad++;
                $display("FAIL ovf[%0d] got s=%h c=%b o=%b want s=%h c=%b o=%b",
                         i, sum, cout, ovf, ws[i], wc[i], wo[i]);
            end
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_carry_in();
        test_no_carry_in();
        test_wraparound();
        test_bit_order();
        test_x_idle();
        test_mid_change();
        test_async_reset();
        test_back_to_back();
`ifdef ADDER8B_OVF_EN
        test_ovf();
`endif
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_left got=%0d want=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
